// File: rtl/crossbar_mvm_engine.sv
// ReRAM crossbar engine: row programming with settle delay and bit-serial
// matrix-vector multiply b = W^T x, sequenced through one valid/ready port.
module crossbar_mvm_engine #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int WBITS        = 2,
  parameter int XBITS        = 4,
  parameter int WRITE_CYCLES = 4,
  localparam int RB          = $clog2(ROWS),
  localparam int OBITS       = WBITS + XBITS + RB
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_op,
  input  logic [RB-1:0]            wr_row,
  input  logic [COLS*WBITS-1:0]    wr_data,
  input  logic [ROWS*XBITS-1:0]    x,
  output logic                     wr_done,
  output logic                     wr_err,
  output logic                     b_valid,
  output logic [COLS*OBITS-1:0]    b,
  output logic                     busy
);

  localparam int CW  = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
  localparam int XIW = (XBITS > 1) ? $clog2(XBITS) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WRITE_CYCLES - 1);
  localparam logic [XIW-1:0] BIT_TOP  = XIW'(XBITS - 1);
  localparam logic [RB:0]    ROWS_LIM = (RB+1)'(ROWS);

  typedef enum logic [1:0] {IDLE, PROG, MAC} state_t;

  state_t           state;
  logic [WBITS-1:0] w_cell   [ROWS][COLS];
  logic [WBITS-1:0] wr_lat   [COLS];
  logic [XBITS-1:0] x_lat    [ROWS];
  logic [OBITS-1:0] acc      [COLS];
  logic [OBITS-1:0] acc_next [COLS];
  logic [RB-1:0]    row_lat;
  logic [CW-1:0]    cnt;
  logic [XIW-1:0]   bit_idx;
  logic             row_ok;

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  // Non-power-of-two ROWS leaves addressable rows that do not exist.
  assign row_ok    = ({1'b0, row_lat} < ROWS_LIM);

  always_comb begin
    for (int unsigned c = 0; c < COLS; c++) begin
      acc_next[c] = acc[c] << 1;
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (x_lat[r][bit_idx]) acc_next[c] = acc_next[c] + OBITS'(w_cell[r][c]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      row_lat <= '0;
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
      b_valid <= 1'b0;
      b       <= '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
        x_lat[r] <= '0;
        for (int unsigned c = 0; c < COLS; c++) w_cell[r][c] <= '0;
      end
      for (int unsigned c = 0; c < COLS; c++) begin
        acc[c]    <= '0;
        wr_lat[c] <= '0;
      end
    end else begin
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
      b_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (!cmd_op) begin
              row_lat <= wr_row;
              for (int unsigned c = 0; c < COLS; c++) wr_lat[c] <= wr_data[c*WBITS +: WBITS];
              cnt   <= '0;
              state <= PROG;
            end else begin
              for (int unsigned r = 0; r < ROWS; r++) x_lat[r] <= x[r*XBITS +: XBITS];
              for (int unsigned c = 0; c < COLS; c++) acc[c] <= '0;
              bit_idx <= BIT_TOP;
              state   <= MAC;
            end
          end
        end
        PROG: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            if (row_ok) begin
              for (int unsigned c = 0; c < COLS; c++) w_cell[row_lat][c] <= wr_lat[c];
            end
            wr_err  <= ~row_ok;
            wr_done <= 1'b1;
            state   <= IDLE;
          end
        end
        MAC: begin
          for (int unsigned c = 0; c < COLS; c++) acc[c] <= acc_next[c];
          bit_idx <= bit_idx - 1'b1;
          if (bit_idx == '0) begin
            for (int unsigned c = 0; c < COLS; c++) b[c*OBITS +: OBITS] <= acc_next[c];
            b_valid <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
